// File: rtl/bg_pkg.sv
// rtl/bg_pkg.sv - shared types and pipeline constants for the background fetch stage
//
// Purpose: texel/colour types used between the VRAM word and the compositor,
//          plus the fixed pipeline latencies of bg_scroll_fetch.
// Ports:   none (package).
package bg_pkg;

  typedef logic [11:0] rgb444_t;

  // VRAM word layout: bit 12 transparent, bits 11:0 {R,G,B}.
  typedef struct packed {
    logic    transparent;
    rgb444_t rgb;
  } texel_t;

  // Inputs to outputs, in pixel clocks.
  localparam int PIPE_LAT = 3;
  // VRAM read data arrives this many clocks after the address register.
  localparam int VRAM_LAT = 1;

endpackage

// File: rtl/bg_scroll_fetch_if.sv
// rtl/bg_scroll_fetch_if.sv - VRAM read port between the fetch stage and background VRAM
//
// Purpose: groups the VRAM address/data pair.
// Ports:   vram_addr (fetch -> VRAM), vram_data (VRAM -> fetch, 1 cycle after addr).
//          master = fetch stage, slave = VRAM.
interface bg_scroll_fetch_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 13
);

  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [DATA_WIDTH-1:0] vram_data;

  modport master (output vram_addr, input vram_data);
  modport slave  (input vram_addr, output vram_data);

endinterface

// File: rtl/bg_scroll_ctrl.sv
// rtl/bg_scroll_ctrl.sv - per-frame vertical scroll offset with deferred clear
//
// Purpose: holds the committed scroll offset; all changes land on frame_start
//          so a visible frame never tears.
// Ports:   clk, rst_n (async active-low)
//          frame_start  - commit strobe, first blanking cycle after last visible line
//          scroll_en    - advance on commit
//          scroll_speed - texel rows subtracted per commit
//          scroll_clr   - clear request, remembered until the next commit
//          scroll_pos   - committed offset
module bg_scroll_ctrl #(
  parameter int IMG_H_LOG2  = 7,
  parameter int SPEED_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   scroll_en,
  input  logic [SPEED_WIDTH-1:0] scroll_speed,
  input  logic                   scroll_clr,
  output logic [IMG_H_LOG2-1:0]  scroll_pos
);

  logic                  clr_pending;
  logic [IMG_H_LOG2-1:0] speed_ext;

  assign speed_ext = IMG_H_LOG2'(scroll_speed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_pos  <= '0;
      clr_pending <= 1'b0;
    end else if (frame_start) begin
      // A clear requested at any point in the frame beats an advance.
      if (clr_pending || scroll_clr) begin
        scroll_pos  <= '0;
        clr_pending <= 1'b0;
      end else if (scroll_en) begin
        // Subtraction wraps modulo the image height: image moves toward the viewer.
        scroll_pos <= scroll_pos - speed_ext;
      end
    end else if (scroll_clr) begin
      clr_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/bg_scroll_fetch.sv
// rtl/bg_scroll_fetch.sv - raster-to-VRAM address stage with 3-cycle aligned RGB output
//
// Purpose: maps hcount/vcount plus the scroll offset to a VRAM texel address,
//          captures the returned word and presents RGB444 + transparency with
//          de/hsync/vsync delayed to match.
// Ports:   clk, rst_n (async active-low)
//          hcount, vcount, de_in, hsync_in, vsync_in - raster inputs (cycle N)
//          frame_start, scroll_en, scroll_speed, scroll_clr - scroll control
//          vram (master) - vram_addr at N+1, vram_data back at N+2
//          rgb, transparent, de_out, hsync_out, vsync_out - outputs at N+3
//          scroll_pos - committed scroll offset
module bg_scroll_fetch
  import bg_pkg::*;
#(
  parameter int IMG_W_LOG2  = 8,
  parameter int IMG_H_LOG2  = 7,
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 13,
  parameter int SCALE_SHIFT = 2,
  parameter int COORD_WIDTH = 10,
  parameter int SPEED_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COORD_WIDTH-1:0]  hcount,
  input  logic [COORD_WIDTH-1:0]  vcount,
  input  logic                    de_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    frame_start,
  input  logic                    scroll_en,
  input  logic [SPEED_WIDTH-1:0]  scroll_speed,
  input  logic                    scroll_clr,
  bg_scroll_fetch_if.master       vram,
  output rgb444_t                 rgb,
  output logic                    transparent,
  output logic                    de_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic [IMG_H_LOG2-1:0]   scroll_pos
);

  bg_scroll_ctrl #(
    .IMG_H_LOG2  (IMG_H_LOG2),
    .SPEED_WIDTH (SPEED_WIDTH)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .scroll_en    (scroll_en),
    .scroll_speed (scroll_speed),
    .scroll_clr   (scroll_clr),
    .scroll_pos   (scroll_pos)
  );

  // Texel coordinates: screen pixels are 2^SCALE_SHIFT per texel; both axes
  // wrap by truncation to the image size.
  logic [COORD_WIDTH-1:0] h_sh;
  logic [COORD_WIDTH-1:0] v_sh;
  logic [IMG_W_LOG2-1:0]  col;
  logic [IMG_H_LOG2-1:0]  row;
  logic                   unused_coord_bits;

  assign h_sh = hcount >> SCALE_SHIFT;
  assign v_sh = vcount >> SCALE_SHIFT;
  assign col  = h_sh[IMG_W_LOG2-1:0];
  assign row  = v_sh[IMG_H_LOG2-1:0] + scroll_pos;
  assign unused_coord_bits = ^{h_sh[COORD_WIDTH-1:IMG_W_LOG2], v_sh[COORD_WIDTH-1:IMG_H_LOG2]};

  logic [ADDR_WIDTH-1:0] addr_q;
  assign vram.vram_addr = addr_q;

  logic [DATA_WIDTH-1:0] vdata;
  texel_t                texel;
  assign vdata = vram.vram_data;
  assign texel = texel_t'(vdata);

  // Bit k of each pipe is the flag at stage k+1.
  logic [PIPE_LAT-1:0] de_pipe;
  logic [PIPE_LAT-1:0] hs_pipe;
  logic [PIPE_LAT-1:0] vs_pipe;
  rgb444_t             rgb_q;
  logic                tr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      de_pipe <= '0;
      hs_pipe <= '0;
      vs_pipe <= '0;
      rgb_q   <= '0;
      tr_q    <= 1'b0;
    end else begin
      // Address runs every cycle; blanking addresses are simply ignored later.
      addr_q  <= {row, col};
      de_pipe <= {de_pipe[PIPE_LAT-2:0], de_in};
      hs_pipe <= {hs_pipe[PIPE_LAT-2:0], hsync_in};
      vs_pipe <= {vs_pipe[PIPE_LAT-2:0], vsync_in};
      // vram_data belongs to the stage VRAM_LAT past the address register.
      if (de_pipe[VRAM_LAT]) begin
        rgb_q <= texel.rgb;
        tr_q  <= texel.transparent;
      end else begin
        rgb_q <= '0;
        tr_q  <= 1'b0;
      end
    end
  end

  assign rgb         = rgb_q;
  assign transparent = tr_q;
  assign de_out      = de_pipe[PIPE_LAT-1];
  assign hsync_out   = hs_pipe[PIPE_LAT-1];
  assign vsync_out   = vs_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_bg_scroll_fetch.sv
// tb/tb_bg_scroll_fetch.sv - self-checking bench for bg_scroll_fetch
module tb_bg_scroll_fetch;
  import bg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic       frame_start = 1'b0, scroll_en = 1'b0, scroll_clr = 1'b0;
  logic [3:0] scroll_speed = '0;
  rgb444_t    rgb;
  logic       transparent, de_out, hsync_out, vsync_out;
  logic [6:0] scroll_pos;

  bg_scroll_fetch_if #(.ADDR_WIDTH(15), .DATA_WIDTH(13)) vif ();

  bg_scroll_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hcount       (hcount),
    .vcount       (vcount),
    .de_in        (de_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .frame_start  (frame_start),
    .scroll_en    (scroll_en),
    .scroll_speed (scroll_speed),
    .scroll_clr   (scroll_clr),
    .vram         (vif),
    .rgb          (rgb),
    .transparent  (transparent),
    .de_out       (de_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .scroll_pos   (scroll_pos)
  );

  always #5 clk = ~clk;

  // VRAM model: 1-cycle registered read of a fixed address-derived pattern.
  bit force_word = 1'b0;
  function automatic logic [12:0] word(input logic [14:0] a);
    if (force_word) return 13'h1ABC;
    return {a[3] ^ a[10], a[11:0] ^ {a[14:12], 9'h0A5}};
  endfunction
  always @(posedge clk) vif.vram_data <= word(vif.vram_addr);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_scroll = 0;
  bit m_pend   = 1'b0;

  typedef struct { int due; logic [14:0] addr; } aexp_t;
  typedef struct { int due; logic [11:0] rgb; logic tr; logic de; logic hs; logic vs; } oexp_t;
  aexp_t aq[$];
  oexp_t oq[$];

  typedef struct { int h; int v; bit de; logic [14:0] exp_addr; } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    aexp_t a;
    oexp_t o;
    @(posedge clk);
    #1;
    cyc++;
    while (aq.size() > 0 && aq[0].due == cyc) begin
      a = aq.pop_front();
      chk("vram_addr", 32'(vif.vram_addr), 32'(a.addr));
    end
    while (oq.size() > 0 && oq[0].due == cyc) begin
      o = oq.pop_front();
      chk("rgb", 32'(rgb), 32'(o.rgb));
      chk("transparent", 32'(transparent), 32'(o.tr));
      chk("de_out", 32'(de_out), 32'(o.de));
      chk("hsync_out", 32'(hsync_out), 32'(o.hs));
      chk("vsync_out", 32'(vsync_out), 32'(o.vs));
    end
    chk("scroll_pos_model", 32'(scroll_pos), 32'(m_scroll));
  endtask

  task automatic drive_a(input int h, input int v, input bit de, input bit fs, input bit clr,
                         input logic [14:0] exp_addr);
    logic [12:0] w;
    bit hs, vs;
    hs = (h % 5 == 0);
    vs = (v == 7);
    w  = word(exp_addr);
    hcount = 10'(h); vcount = 10'(v);
    de_in = de; hsync_in = hs; vsync_in = vs;
    frame_start = fs; scroll_clr = clr;
    aq.push_back('{cyc + 1, exp_addr});
    oq.push_back('{cyc + 3, de ? w[11:0] : 12'h000, de ? w[12] : 1'b0, de, hs, vs});
    if (fs) begin
      if (m_pend || clr) begin
        m_scroll = 0; m_pend = 1'b0;
      end else if (scroll_en) begin
        m_scroll = (m_scroll - int'(scroll_speed) + 128) % 128;
      end
    end else if (clr) begin
      m_pend = 1'b1;
    end
    tick();
    frame_start = 1'b0; scroll_clr = 1'b0;
  endtask

  task automatic drive(input int h, input int v, input bit de, input bit fs, input bit clr);
    int row, col;
    col = (h >> 2) % 256;
    row = ((v >> 2) + m_scroll) % 128;
    drive_a(h, v, de, fs, clr, 15'(row * 256 + col));
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drive(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reach_five();
    scroll_en = 1'b1;
    scroll_speed = 4'd15;
    for (int i = 0; i < 8; i++) drive(0, 0, 1'b0, 1'b1, 1'b0);
    scroll_speed = 4'd3;
    drive(0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  int exp_s[3];

  initial begin
    vt[0]  = '{0, 0, 1'b1, 15'h0000};
    vt[1]  = '{1, 0, 1'b1, 15'h0000};
    vt[2]  = '{2, 0, 1'b1, 15'h0000};
    vt[3]  = '{3, 0, 1'b1, 15'h0000};
    vt[4]  = '{4, 0, 1'b1, 15'h0001};
    vt[5]  = '{5, 0, 1'b1, 15'h0001};
    vt[6]  = '{6, 0, 1'b1, 15'h0001};
    vt[7]  = '{7, 0, 1'b1, 15'h0001};
    vt[8]  = '{1020, 4, 1'b1, 15'h01FF};
    vt[9]  = '{1023, 4, 1'b1, 15'h01FF};
    vt[10] = '{0, 4, 1'b1, 15'h0100};
    vt[11] = '{8, 8, 1'b0, 15'h0202};
    exp_s[0] = 125; exp_s[1] = 122; exp_s[2] = 119;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(vif.vram_addr), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_tr", 32'(transparent), 0);
    chk("rst_de", 32'(de_out), 0);
    chk("rst_hs", 32'(hsync_out), 0);
    chk("rst_vs", 32'(vsync_out), 0);
    chk("rst_scroll", 32'(scroll_pos), 0);
    rst_n = 1'b1;

    // Address table, scroll 0
    for (int i = 0; i < 12; i++)
      drive_a(vt[i].h, vt[i].v, vt[i].de, 1'b0, 1'b0, vt[i].exp_addr);
    drain();

    // Scroll advance with wrap below zero
    scroll_en = 1'b1;
    scroll_speed = 4'd3;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      chk("scroll_step", 32'(scroll_pos), 32'(exp_s[k]));
    end
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    chk("addr_row119", 32'(vif.vram_addr), 32'h7700);
    drain();
    scroll_speed = 4'd0;
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    chk("speed0_hold", 32'(scroll_pos), 119);

    // Deferred clear
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    reach_five();
    chk("scroll_five", 32'(scroll_pos), 5);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    chk("clr_deferred", 32'(scroll_pos), 5);
    for (int i = 0; i < 4; i++) drive(16 * i, 12, 1'b1, 1'b0, 1'b0);
    chk("clr_still_five", 32'(scroll_pos), 5);
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    chk("clr_commit", 32'(scroll_pos), 0);
    reach_five();
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    chk("clr_beats_adv", 32'(scroll_pos), 0);
    drain();

    // de gating with a fixed VRAM word
    force_word = 1'b1;
    drive(12, 20, 1'b1, 1'b0, 1'b0);
    drive(13, 20, 1'b0, 1'b0, 1'b0);
    drive(14, 20, 1'b1, 1'b0, 1'b0);
    drain();
    force_word = 1'b0;

    // Async reset mid-line with outputs nonzero
    scroll_speed = 4'd3;
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(40 + 4 * i, 30, 1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(vif.vram_addr), 0);
    chk("arst_rgb", 32'(rgb), 0);
    chk("arst_tr", 32'(transparent), 0);
    chk("arst_de", 32'(de_out), 0);
    chk("arst_hs", 32'(hsync_out), 0);
    chk("arst_vs", 32'(vsync_out), 0);
    chk("arst_scroll", 32'(scroll_pos), 0);
    aq.delete();
    oq.delete();
    m_scroll = 0;
    m_pend = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive(100 + 4 * i, 50, 1'b1, 1'b0, 1'b0);
    drain();
    chk("post_rst_scroll", 32'(scroll_pos), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bg_scroll_fetch.md
Name: bg_scroll_fetch

Overview:
- Pixel-pipeline stage directly upstream of the background VRAM.
- Converts VGA raster coordinates plus a vertically scrolling offset into VRAM read addresses.
- Consumes the VRAM's 1-cycle-latency data word and emits RGB444 plus a transparency flag to the compositor.
- Delays de/hsync/vsync so they stay aligned with the pixel data.

Parameters:
- IMG_W_LOG2, 8, log2 of background image width in texels (256).
- IMG_H_LOG2, 7, log2 of background image height in texels (128).
- ADDR_WIDTH, 15, VRAM address width; must equal IMG_W_LOG2+IMG_H_LOG2.
- DATA_WIDTH, 13, VRAM word width: bit 12 = transparent, bits 11:0 = RGB444 {R[3:0],G[3:0],B[3:0]}.
- SCALE_SHIFT, 2, screen pixels per texel = 2^SCALE_SHIFT in both axes.
- COORD_WIDTH, 10, width of hcount/vcount.
- SPEED_WIDTH, 4, width of scroll speed.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- hcount  in  COORD_WIDTH  current raster column.
- vcount  in  COORD_WIDTH  current raster row.
- de_in  in  1  active-video flag for hcount/vcount.
- hsync_in  in  1  horizontal sync, same cycle as hcount.
- vsync_in  in  1  vertical sync, same cycle as hcount.
- frame_start  in  1  one-cycle pulse at the first blanking cycle after the last visible line.
- scroll_en  in  1  enable per-frame scroll advance.
- scroll_speed  in  SPEED_WIDTH  texel rows advanced per frame.
- scroll_clr  in  1  request scroll reset to 0 (pulse).
- vram_addr  out  ADDR_WIDTH  registered VRAM read address.
- vram_data  in  DATA_WIDTH  VRAM read data, valid 1 cycle after vram_addr.
- rgb  out  12  background pixel colour.
- transparent  out  1  texel transparency flag.
- de_out  out  1  de_in delayed 3 cycles.
- hsync_out  out  1  hsync_in delayed 3 cycles.
- vsync_out  out  1  vsync_in delayed 3 cycles.
- scroll_pos  out  IMG_H_LOG2  current committed scroll offset (for sprite alignment).

Behaviour:
- Reset (rst_n low, asynchronous): every register clears to 0.
  - Clears vram_addr, rgb, transparent, de_out, hsync_out, vsync_out, scroll_pos, the clear-pending flag and all pipeline stages.
- Address (stage 1, cycle N+1 for inputs at N):
  - col = hcount >> SCALE_SHIFT, truncated to IMG_W_LOG2 bits, so it wraps horizontally.
  - row = ((vcount >> SCALE_SHIFT) + scroll_pos) mod 2^IMG_H_LOG2.
  - vram_addr <= {row, col}.
  - The address is updated every cycle regardless of de_in.
- Stage 2 (N+2): VRAM presents data; de/hsync/vsync carried one more stage.
- Output (stage 3, N+3):
  - If the delayed de is 1: rgb <= vram_data[11:0], transparent <= vram_data[12].
  - Otherwise rgb <= 0, transparent <= 0.
  - Syncs registered alongside. Total latency from inputs to outputs is exactly 3 cycles.
- Scroll state (commits only on frame_start, so a frame never tears):
  - scroll_clr at any cycle sets clr_pending.
  - On frame_start with clr_pending set, or with scroll_clr high in the same cycle: scroll_pos <= 0, clr_pending <= 0. Clear wins over advance.
  - Else on frame_start with scroll_en: scroll_pos <= (scroll_pos - scroll_speed) mod 2^IMG_H_LOG2. Image moves toward the viewer; wraps below 0.
  - Else scroll_pos holds.
  - scroll_speed = 0 with scroll_en holds the position.
- Changing scroll_speed or scroll_en mid-frame has no visible effect until the next frame_start.
- Reset mid-frame: outputs return to 0 immediately; the pipeline refills and the first valid output is 3 cycles after rst_n deasserts and inputs resume.

Decomposition:
- Package bg_pkg holds:
  - typedef rgb444_t (12 bits);
  - a packed texel_t struct {transparent, rgb444_t};
  - localparams PIPE_LAT = 3 and VRAM_LAT = 1.
- One sub-module is natural: bg_scroll_ctrl.
  - Owns scroll_pos, clr_pending and the frame_start commit logic.
  - The top module holds the address computation and the 3-stage sync/data pipeline.

Test Plan:
- Reset then hcount=0..7, vcount=0, de_in=1, scroll 0 -> vram_addr = 0,0,0,0,1,1,1,1 at N+1; rgb equals the model VRAM word[11:0] at N+3.
- hcount=1020, vcount=4, scroll_pos=0 -> vram_addr = {7'd1, 8'd255}; hcount=1024-equivalent wrap gives col 0.
- scroll_en=1, scroll_speed=3, three frame_start pulses from 0 -> scroll_pos = 125, 122, 119; vcount=0 then addresses row 119.
- scroll_pos=5, scroll_clr pulsed mid-frame -> scroll_pos stays 5 until the next frame_start, then 0. Clear and frame_start in the same cycle with speed 3 -> 0, not 2.
- de_in toggles 1,0,1 with VRAM word 13'h1ABC -> de_out follows 3 cycles later; rgb = 12'hABC, transparent = 1 only in de cycles, else 0.
- rst_n asserted mid-line with outputs nonzero -> all outputs 0 within the same cycle; scroll_pos 0 after release.
